sram_like_arb: RTL and testbench
================================

SRAM_LIKE_ARB -- requirements
Module: sram_like_arb

Interface
REQ-001 Parameter OUTS_DEPTH, default 4, is the maximum number of accepted requests still awaiting data_ok; legal values are 2, 4 and 8.
REQ-002 Port `clk`: input, 1 bit, clock; all state updates on the rising edge.
REQ-003 Port `reset`: input, 1 bit, synchronous, active-high reset.
REQ-004 Port group `inst_req/inst_wr/inst_size/inst_wstrb/inst_addr/inst_wdata`: input, 1/1/2/4/32/32 bits, instruction master request.
REQ-005 Port group `inst_addr_ok/inst_data_ok`: output, 1/1 bits, instruction master handshakes.
REQ-006 Port `inst_rdata`: output, 32 bits, instruction read data.
REQ-007 Port group `data_req/data_wr/data_size/data_wstrb/data_addr/data_wdata`: input, 1/1/2/4/32/32 bits, data master request.
REQ-008 Port group `data_addr_ok/data_data_ok`: output, 1/1 bits, data master handshakes.
REQ-009 Port `data_rdata`: output, 32 bits, data read data.
REQ-010 Port group `mem_req/mem_wr/mem_size/mem_wstrb/mem_addr/mem_wdata`: output, 1/1/2/4/32/32 bits, shared slave request.
REQ-011 Port group `mem_addr_ok/mem_data_ok/mem_rdata`: input, 1/1/32 bits, slave handshakes and read data.
REQ-012 Port `spurious_err`: output, 1 bit, sticky flag; set when mem_data_ok arrives with no request outstanding.

Function
REQ-013 Grant selection is combinational when unlocked and the tag FIFO is not full:
- data_req=1 grants DATA;
- otherwise inst_req=1 grants INST;
- otherwise there is no grant.
REQ-014 mem_req SHALL be 1 only when a grant exists and the tag FIFO is not full.
REQ-015 mem_wr, mem_size, mem_wstrb, mem_addr and mem_wdata SHALL carry the granted master's fields; with no grant they SHALL be 0.
REQ-016 Lock rule: if mem_req=1 and mem_addr_ok=0 in a cycle, the grant is registered as locked.
- While locked, the locked master keeps the grant regardless of priority.
- The lock clears on the cycle mem_req and mem_addr_ok are both 1.
REQ-017 inst_addr_ok = mem_req & mem_addr_ok & grant==INST; data_addr_ok = mem_req & mem_addr_ok & grant==DATA; at most one is 1 per cycle.
REQ-018 Every mem_req & mem_addr_ok pushes a 1-bit tag into an in-order FIFO of OUTS_DEPTH entries; tag 0 means INST, 1 means DATA.
REQ-019 Response routing:
- mem_data_ok with the FIFO non-empty pops the head entry.
- It drives inst_data_ok=1 for head tag 0, or data_data_ok=1 for head tag 1, in the same cycle (combinational, zero latency).
REQ-020 inst_rdata and data_rdata SHALL both equal mem_rdata at all times.
REQ-021 Occupancy counter ranges 0..OUTS_DEPTH.
- Simultaneous push and pop leaves the count unchanged and keeps order.
- Read and write pointers wrap modulo OUTS_DEPTH.
REQ-022 Full (count==OUTS_DEPTH) blocks new requests through mem_req=0.
- A pop in the same cycle does not unblock them; there is no bypass.
- A request already locked stays presented with mem_req=0 until space frees.
REQ-023 mem_data_ok with an empty FIFO:
- asserts no master data_ok;
- changes no pointers;
- sets spurious_err=1 from the next cycle until reset.
REQ-024 A response for an entry pushed this cycle cannot be delivered this cycle; a pop requires count>0 at the start of the cycle.
REQ-025 Writes (mem_wr=1) are tagged and routed identically to reads, and each expects exactly one mem_data_ok.

Reset
REQ-026 While reset=1, the outputs are: mem_req=0, all addr_ok/data_ok=0, mem_* fields=0, spurious_err=0.
REQ-027 Reset clears the lock, the FIFO pointers and the count to 0.
REQ-028 Reset mid-transaction discards all outstanding tags; any later mem_data_ok for pre-reset requests sets spurious_err.
REQ-029 No grant is issued in the cycle reset is asserted; arbitration resumes in the first cycle with reset=0.

Verification
REQ-030 Scenario, simultaneous requests:
- Stimulus: inst_req=1, data_req=1, mem_addr_ok=1 for one cycle.
- Response: data_addr_ok=1 and mem_addr equals data_addr.
- Next cycle: inst_addr_ok=1.
- Tags pushed in order: 1, then 0.
REQ-031 Scenario, lock held:
- Stimulus: inst_req=1 with mem_addr_ok=0 for 3 cycles, data_req rises in cycle 2.
- Response: mem_addr stays at inst_addr until mem_addr_ok=1; DATA is granted next.
REQ-032 Scenario, in-order routing:
- Stimulus: accept INST at 0xbfc00000, then DATA at 0x80001000, then two mem_data_ok with rdata 0x24080001 and 0x12345678.
- Response: inst_data_ok pulses with 0x24080001 first, then data_data_ok with 0x12345678.
REQ-033 Scenario, full then pop:
- Stimulus: OUTS_DEPTH=4 accepts without responses.
- Response: mem_req=0 while both masters request.
- One mem_data_ok: mem_req=1 from the next cycle.
REQ-034 Scenario, spurious response:
- Stimulus: mem_data_ok=1 with count=0.
- Response: no master data_ok; spurious_err=1 the next cycle and it stays 1.
REQ-035 Scenario, reset with outstanding tags:
- Stimulus: reset with 2 tags outstanding.
- Response: count=0; a following mem_data_ok produces no data_ok and sets spurious_err.

Source files
------------

// File: rtl/sram_like_arb.sv
// Two-master SRAM-like arbiter: DATA has priority over INST, a grant stays locked while the
// slave withholds addr_ok, and an in-order tag FIFO routes each data_ok back to its master.
module sram_like_arb #(
  parameter int unsigned OUTS_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  // Instruction master
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  // Data master
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  // Shared slave
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        spurious_err
);

  localparam int unsigned PtrW = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(OUTS_DEPTH + 1);

  typedef enum logic [1:0] {StFree, StLockInst, StLockData} lock_e;
  typedef enum logic [1:0] {GntNone, GntInst, GntData} gnt_e;

  lock_e                 state_q, state_d;
  gnt_e                  grant;
  logic [OUTS_DEPTH-1:0] tag_q;       // 0 = INST, 1 = DATA
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q;
  logic                  spurious_q;
  logic                  full, empty, push, pop, head_tag;

  assign full     = (count_q == CntW'(OUTS_DEPTH));
  assign empty    = (count_q == '0);
  assign head_tag = tag_q[rd_ptr_q];

  // Grant: a locked master keeps it; otherwise DATA beats INST, and nothing new while full.
  always_comb begin
    grant = GntNone;
    if (!reset) begin
      case (state_q)
        StLockInst: grant = GntInst;
        StLockData: grant = GntData;
        default: begin
          if (!full) begin
            if (data_req)      grant = GntData;
            else if (inst_req) grant = GntInst;
          end
        end
      endcase
    end
  end

  assign mem_req = (grant != GntNone) && !full;
  assign push    = mem_req && mem_addr_ok;
  // Pop only against entries present at the start of the cycle; no same-cycle bypass.
  assign pop     = !reset && mem_data_ok && !empty;

  // Forward the granted master's request fields; zero when nobody is granted.
  always_comb begin
    mem_wr    = 1'b0;
    mem_size  = 2'd0;
    mem_wstrb = 4'd0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    case (grant)
      GntInst: begin
        mem_wr    = inst_wr;
        mem_size  = inst_size;
        mem_wstrb = inst_wstrb;
        mem_addr  = inst_addr;
        mem_wdata = inst_wdata;
      end
      GntData: begin
        mem_wr    = data_wr;
        mem_size  = data_size;
        mem_wstrb = data_wstrb;
        mem_addr  = data_addr;
        mem_wdata = data_wdata;
      end
      default: ;
    endcase
  end

  assign inst_addr_ok = push && (grant == GntInst);
  assign data_addr_ok = push && (grant == GntData);
  assign inst_data_ok = pop && !head_tag;
  assign data_data_ok = pop && head_tag;
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;
  assign spurious_err = spurious_q && !reset;

  // Lock next state: a stalled request pins its master until the slave accepts it.
  always_comb begin
    state_d = state_q;
    if (reset) begin
      state_d = StFree;
    end else if (mem_req && !mem_addr_ok) begin
      state_d = (grant == GntData) ? StLockData : StLockInst;
    end else if (push) begin
      state_d = StFree;
    end
  end

  // Lock state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= StFree;
    else       state_q <= state_d;
  end

  // Tag FIFO: pointers wrap naturally since the depth is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        tag_q[wr_ptr_q] <= (grant == GntData);
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop)      count_q <= count_q + CntW'(1);
      else if (!push && pop) count_q <= count_q - CntW'(1);
    end
  end

  // Sticky flag for a response arriving with nothing outstanding.
  always_ff @(posedge clk) begin
    if (reset)                     spurious_q <= 1'b0;
    else if (mem_data_ok && empty) spurious_q <= 1'b1;
  end

endmodule

// File: tb/tb_sram_like_arb.sv
// Scoreboard bench: a queue-based model predicts handshakes per cycle and queues expected
// responses; a negedge monitor pops them whenever the DUT raises a data_ok.
module tb_sram_like_arb;

  localparam int unsigned Depth = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size, mem_size;
  logic [3:0]  inst_wstrb, data_wstrb, mem_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok, spurious_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  sram_like_arb #(.OUTS_DEPTH(Depth)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata), .spurious_err(spurious_err)
  );

  typedef struct {
    int unsigned master;  // 1 = INST, 2 = DATA
    logic [31:0] rdata;
  } resp_t;

  int          checks = 0;
  int          errors = 0;
  int unsigned out_q[$];   // masters with accepted requests awaiting data, oldest first
  resp_t       exp_resp[$];
  resp_t       mon_r;
  int unsigned lock_m = 0; // master pinned by a stalled request, 0 = none
  bit          spur = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    {inst_req, inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata} = '0;
    {data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata} = '0;
    {mem_addr_ok, mem_data_ok, mem_rdata} = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Predict this cycle's outputs from the model state, compare, then advance the model.
  task automatic eval();
    int unsigned gnt;
    bit          exp_req;
    logic [70:0] exp_fields;
    #1;
    gnt = 0;
    if (!reset) begin
      if (lock_m != 0)             gnt = lock_m;
      else if (out_q.size() < Depth) gnt = data_req ? 2 : (inst_req ? 1 : 0);
    end
    exp_req = (gnt != 0) && (out_q.size() < Depth);
    if (gnt == 2)      exp_fields = {data_wr, data_size, data_wstrb, data_addr, data_wdata};
    else if (gnt == 1) exp_fields = {inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata};
    else               exp_fields = '0;
    check("mem_req", 128'(mem_req), 128'(exp_req));
    check("mem_fields", 128'({mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata}),
          128'(exp_fields));
    check("addr_ok", 128'({inst_addr_ok, data_addr_ok}),
          128'({exp_req && mem_addr_ok && gnt == 1, exp_req && mem_addr_ok && gnt == 2}));
    check("rdata_pass", 128'({inst_rdata, data_rdata}), 128'({mem_rdata, mem_rdata}));
    check("spurious_err", 128'(spurious_err), 128'(!reset && spur));
    if (reset) begin
      out_q.delete();
      lock_m = 0;
      spur   = 1'b0;
    end else begin
      if (mem_data_ok) begin
        if (out_q.size() > 0) exp_resp.push_back('{out_q.pop_front(), mem_rdata});
        else                  spur = 1'b1;
      end
      if (exp_req && mem_addr_ok) out_q.push_back(gnt);
      if (exp_req) lock_m = mem_addr_ok ? 0 : gnt;
    end
  endtask

  // Monitor: every data_ok must match the oldest expected response, and none may be missed.
  always @(negedge clk) begin
    if (inst_data_ok || data_data_ok) begin
      if (exp_resp.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_data_ok: got inst=%0b data=%0b expected none at %0t",
                 inst_data_ok, data_data_ok, $time);
      end else begin
        mon_r = exp_resp.pop_front();
        check("resp_route", 128'({inst_data_ok, data_data_ok}),
              128'((mon_r.master == 1) ? 2'b10 : 2'b01));
        check("resp_rdata", 128'(mon_r.master == 1 ? inst_rdata : data_rdata),
              128'(mon_r.rdata));
      end
    end else if (exp_resp.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL missing_data_ok: got none expected master %0d at %0t",
               exp_resp[0].master, $time);
      exp_resp.delete();
    end
  end

  initial begin
    int unsigned p_req, p_aok, p_dok;
    clear_inputs();
    reset = 1'b1;
    repeat (2) begin tick(); eval(); end
    reset = 1'b0;

    // Simultaneous requests: DATA first, then INST.
    tick(); clear_inputs(); inst_req = 1; data_req = 1; mem_addr_ok = 1;
    inst_addr = 32'h0000_1000; data_addr = 32'h0000_2000; eval();
    tick(); data_req = 0; eval();
    // Responses in tag order DATA then INST.
    tick(); inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'haaaa_0001; eval();
    tick(); mem_rdata = 32'hbbbb_0002; eval();

    // In-order routing with fixed addresses and read data.
    tick(); clear_inputs(); inst_req = 1; inst_addr = 32'hbfc0_0000; mem_addr_ok = 1; eval();
    tick(); inst_req = 0; data_req = 1; data_addr = 32'h8000_1000; eval();
    tick(); data_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h2408_0001; eval();
    tick(); mem_rdata = 32'h1234_5678; eval();

    // Spurious response then a sticky flag.
    tick(); clear_inputs(); mem_data_ok = 1; eval();
    repeat (3) begin tick(); clear_inputs(); eval(); end

    // Randomized rounds, each starting from reset with its own traffic mix.
    for (int round = 0; round < 8; round++) begin
      tick(); clear_inputs(); reset = 1'b1; eval();
      p_req = $urandom_range(30, 100);
      p_aok = $urandom_range(20, 100);
      p_dok = $urandom_range(10, 90);
      for (int cyc = 0; cyc < 200; cyc++) begin
        tick();
        reset       = ($urandom_range(0, 149) == 0);
        inst_req    = ($urandom_range(0, 99) < p_req);
        data_req    = ($urandom_range(0, 99) < p_req);
        inst_wr     = 1'($urandom);
        data_wr     = 1'($urandom);
        inst_size   = 2'($urandom);
        data_size   = 2'($urandom);
        inst_wstrb  = 4'($urandom);
        data_wstrb  = 4'($urandom);
        inst_addr   = $urandom;
        data_addr   = $urandom;
        inst_wdata  = $urandom;
        data_wdata  = $urandom;
        mem_addr_ok = ($urandom_range(0, 99) < p_aok);
        mem_rdata   = $urandom;
        mem_data_ok = ($urandom_range(0, 99) < p_dok) &&
                      (out_q.size() > 0 || $urandom_range(0, 39) == 0);
        eval();
      end
    end

    tick(); clear_inputs(); reset = 1'b0; eval();
    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
